gfp8_group_packer: RTL and testbench

//  Re-encodes a stream of dot-product results (signed 32-bit mantissa x 2^signed 8-bit exponent)

---
 rtl/gfp8_group_packer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_gfp8_group_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfp8_group_packer.sv
// ---------------------------------------------------------------------------
// gfp8_group_packer
//  Packs a stream of dot-product results (signed 32-bit mantissa scaled by
//  2^signed 8-bit exponent) into one GFP8 group: 32 signed 8-bit mantissas
//  that share a single 5-bit biased exponent.
//
//  Ports
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_valid / o_ready      element handshake (accept = i_valid & o_ready)
//   i_mantissa[31:0]       signed element mantissa
//   i_exponent[7:0]        signed element exponent
//   i_last                 closes the group early (remainder zero-padded)
//   o_valid / i_ready      group handshake
//   o_exp[7:0]             {3'b0, biased shared exponent}
//   o_man[255:0]           element i in bits [8i+7:8i]
//   o_count[5:0]           number of real elements, 1..32
//   o_ovf / o_unf          shared exponent clamped high / low
// ---------------------------------------------------------------------------
module gfp8_group_packer #(
   parameter int LANES    = 8,
   parameter int EXP_BIAS = 15
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [31:0]  i_mantissa,
   input  logic [7:0]   i_exponent,
   input  logic         i_last,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [7:0]   o_exp,
   output logic [255:0] o_man,
   output logic [5:0]   o_count,
   output logic         o_ovf,
   output logic         o_unf
);

   localparam int N_NORM = 32 / LANES;
   localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);

   // ST_RESET only exists so that o_ready stays low while reset is held.
   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_COLLECT = 2'd1,
      ST_NORM    = 2'd2,
      ST_OUT     = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [4:0]          idx_r;
   logic [5:0]          norm_cnt_r;
   logic [5:0]          count_r;
   logic [31:0]         buf_man_r [32];
   logic [7:0]          buf_exp_r [32];
   logic signed [9:0]   rmax_r;
   logic                any_nz_r;

   logic                o_ready_r, o_valid_r, o_ovf_r, o_unf_r;
   logic [7:0]          o_exp_r;
   logic [255:0]        o_man_r;
   logic [5:0]          o_count_r;

   logic                accept_s, close_s;
   logic signed [9:0]   r_new_s;
   logic signed [9:0]   eb_full_s, e_grp_s;
   logic [4:0]          eb_s;
   logic                ovf_s, unf_s;
   logic [5:0]          lane_idx_s  [LANES];
   logic signed [9:0]   lane_sh_s   [LANES];
   logic [7:0]          lane_byte_s [LANES];

   // 33-bit wide absolute value so that -2^31 yields a magnitude of 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] m);
      logic [32:0] a;
      if (m[31]) begin
         a = 33'd0 - {1'b1, m};
      end else begin
         a = {1'b0, m};
      end
      return a[31:0];
   endfunction

   // Number of significant bits of |m| (0 for m == 0, 32 for -2^31).
   function automatic logic [5:0] sig_width(input logic [31:0] m);
      logic [31:0] a;
      logic [5:0]  w;
      a = abs32(m);
      w = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (a[i]) begin
            w = 6'(i + 1);
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   // Scale one element to the shared exponent: shift, saturate to 127, resign.
   function automatic logic [7:0] norm_elem(input logic [31:0] m,
                                            input logic signed [9:0] s);
      logic [31:0] mag;
      logic [39:0] wide;
      logic [9:0]  ns;
      logic [6:0]  sat;
      mag  = abs32(m);
      wide = 40'd0;
      ns   = 10'd0;
      if (s >= 10'sd32) begin
         wide = 40'd0;
      end else if (s >= 10'sd0) begin
         wide = {8'd0, mag >> s[4:0]};
      end else begin
         ns = 10'd0 - $unsigned(s);
         // Any nonzero magnitude shifted left by more than 8 saturates.
         if (ns > 10'd8) begin
            wide = (mag != 32'd0) ? 40'd128 : 40'd0;
         end else begin
            wide = {8'd0, mag} << ns[3:0];
         end
      end
      sat = (wide > 40'd127) ? 7'd127 : wide[6:0];
      return m[31] ? (8'd0 - {1'b0, sat}) : {1'b0, sat};
   endfunction

   // Element handshake and the exponent score r = e + w - 7 of the incoming element.
   always_comb begin
      accept_s = i_valid & o_ready_r;
      close_s  = accept_s & ((idx_r == 5'd31) | i_last);
      r_new_s  = $signed({{2{i_exponent[7]}}, i_exponent})
               + $signed({4'd0, sig_width(i_mantissa)}) - 10'sd7;
   end

   // Shared exponent selection with clamping to the 5-bit biased range.
   always_comb begin
      eb_full_s = rmax_r + BIAS_S;
      eb_s      = 5'd0;
      e_grp_s   = 10'sd0;
      ovf_s     = 1'b0;
      unf_s     = 1'b0;
      if (!any_nz_r) begin
         eb_s    = 5'd0;
         e_grp_s = 10'sd0;
      end else if (eb_full_s > 10'sd31) begin
         eb_s    = 5'd31;
         e_grp_s = 10'sd31 - BIAS_S;
         ovf_s   = 1'b1;
      end else if (eb_full_s < 10'sd0) begin
         eb_s    = 5'd0;
         e_grp_s = 10'sd0 - BIAS_S;
         unf_s   = 1'b1;
      end else begin
         eb_s    = eb_full_s[4:0];
         e_grp_s = rmax_r;
      end
   end

   // Per-lane normalisation of the LANES elements handled this cycle.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx_s[l]  = 6'(int'(norm_cnt_r) * LANES + l);
         lane_sh_s[l]   = e_grp_s - $signed({{2{buf_exp_r[lane_idx_s[l][4:0]][7]}},
                                              buf_exp_r[lane_idx_s[l][4:0]]});
         lane_byte_s[l] = 8'd0;
         if (lane_idx_s[l] < count_r) begin
            lane_byte_s[l] = norm_elem(buf_man_r[lane_idx_s[l][4:0]], lane_sh_s[l]);
         end else begin
            lane_byte_s[l] = 8'd0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_RESET:   state_s = ST_COLLECT;
         ST_COLLECT: begin
            if (close_s) state_s = ST_NORM;
            else         state_s = ST_COLLECT;
         end
         ST_NORM: begin
            if (norm_cnt_r == 6'(N_NORM - 1)) state_s = ST_OUT;
            else                              state_s = ST_NORM;
         end
         ST_OUT: begin
            if (i_ready) state_s = ST_COLLECT;
            else         state_s = ST_OUT;
         end
         default:    state_s = ST_COLLECT;
      endcase
   end

   // State register and registered handshake outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r   <= ST_RESET;
         o_ready_r <= 1'b0;
         o_valid_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         o_ready_r <= (state_s == ST_COLLECT);
         o_valid_r <= (state_s == ST_OUT);
      end
   end

   // Element buffer, running maximum, normaliser sequencing and packed result.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         idx_r      <= 5'd0;
         norm_cnt_r <= 6'd0;
         count_r    <= 6'd0;
         rmax_r     <= 10'sd0;
         any_nz_r   <= 1'b0;
         o_exp_r    <= 8'd0;
         o_man_r    <= 256'd0;
         o_count_r  <= 6'd0;
         o_ovf_r    <= 1'b0;
         o_unf_r    <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            buf_man_r[i] <= 32'd0;
            buf_exp_r[i] <= 8'd0;
         end
      end else begin
         case (state_r)
            ST_COLLECT: begin
               norm_cnt_r <= 6'd0;
               if (accept_s) begin
                  buf_man_r[idx_r] <= i_mantissa;
                  buf_exp_r[idx_r] <= i_exponent;
                  // Zero mantissas carry no magnitude and never steer the exponent.
                  if (i_mantissa != 32'd0) begin
                     if (!any_nz_r || (r_new_s > rmax_r)) begin
                        rmax_r <= r_new_s;
                     end
                     any_nz_r <= 1'b1;
                  end
                  if (close_s) begin
                     idx_r   <= 5'd0;
                     count_r <= {1'b0, idx_r} + 6'd1;
                  end else begin
                     idx_r   <= idx_r + 5'd1;
                  end
               end
            end
            ST_NORM: begin
               norm_cnt_r <= norm_cnt_r + 6'd1;
               for (int l = 0; l < LANES; l++) begin
                  o_man_r[8 * int'(lane_idx_s[l]) +: 8] <= lane_byte_s[l];
               end
               o_exp_r   <= {3'b000, eb_s};
               o_ovf_r   <= ovf_s;
               o_unf_r   <= unf_s;
               o_count_r <= count_r;
            end
            ST_OUT: begin
               if (i_ready) begin
                  any_nz_r <= 1'b0;
               end
            end
            default: begin
               norm_cnt_r <= 6'd0;
            end
         endcase
      end
   end

   assign o_ready = o_ready_r;
   assign o_valid = o_valid_r;
   assign o_exp   = o_exp_r;
   assign o_man   = o_man_r;
   assign o_count = o_count_r;
   assign o_ovf   = o_ovf_r;
   assign o_unf   = o_unf_r;

endmodule

// File: tb/tb_gfp8_group_packer.sv
// ---------------------------------------------------------------------------
// tb_gfp8_group_packer
//  Directed and randomized groups for gfp8_group_packer, checked against an
//  arithmetic reference model of the GFP8 packing rules.
// ---------------------------------------------------------------------------
module tb_gfp8_group_packer;

   logic         i_clk = 1'b0;
   logic         i_reset_n;
   logic         i_valid;
   logic         o_ready;
   logic [31:0]  i_mantissa;
   logic [7:0]   i_exponent;
   logic         i_last;
   logic         o_valid;
   logic         i_ready;
   logic [7:0]   o_exp;
   logic [255:0] o_man;
   logic [5:0]   o_count;
   logic         o_ovf;
   logic         o_unf;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int gm [32];
   int ge [32];
   int gn;
   bit glast;

   gfp8_group_packer #(.LANES(8), .EXP_BIAS(15)) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_mantissa (i_mantissa),
      .i_exponent (i_exponent),
      .i_last     (i_last),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_exp      (o_exp),
      .o_man      (o_man),
      .o_count    (o_count),
      .o_ovf      (o_ovf),
      .o_unf      (o_unf)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Reference: shared exponent from the largest e + bitlength - 7, then
   // each element is |m| * 2^(e - E), truncated and saturated to 127.
   task automatic model(output logic [7:0] xe, output logic [255:0] xm,
                        output logic xo, output logic xu);
      longint a, t, r, rmax, E, Eb, s, mag, val;
      int     w;
      bit     nz;
      nz = 0; rmax = 0;
      xe = 8'h00; xm = '0; xo = 1'b0; xu = 1'b0;
      for (int i = 0; i < gn; i++) begin
         a = longint'(gm[i]);
         if (a < 0) a = -a;
         if (a != 0) begin
            w = 0; t = a;
            while (t > 0) begin w++; t = t >> 1; end
            r = longint'(ge[i]) + w - 7;
            if (!nz || r > rmax) rmax = r;
            nz = 1;
         end
      end
      if (nz) begin
         E  = rmax;
         Eb = rmax + 15;
         if (Eb > 31) begin Eb = 31; E = 16; xo = 1'b1; end
         else if (Eb < 0) begin Eb = 0; E = -15; xu = 1'b1; end
         xe = 8'(Eb);
         for (int i = 0; i < gn; i++) begin
            a = longint'(gm[i]);
            if (a < 0) a = -a;
            s = E - longint'(ge[i]);
            if (s >= 32)      mag = 0;
            else if (s >= 0)  mag = a >> s;
            else if (-s > 30) mag = (a != 0) ? 128 : 0;
            else              mag = a << (-s);
            if (mag > 127) mag = 127;
            val = (gm[i] < 0) ? -mag : mag;
            xm[8*i +: 8] = val[7:0];
         end
      end
   endtask

   task automatic fill(input int m, input int e, input int n, input bit last);
      for (int i = 0; i < 32; i++) begin gm[i] = 0; ge[i] = 0; end
      for (int i = 0; i < n; i++) begin gm[i] = m; ge[i] = e; end
      gn = n; glast = last;
   endtask

   // Feeds the group held in gm/ge/gn, waits for the packed result,
   // stalls the output for 'stall' cycles, then completes the handshake.
   task automatic run_group(input string tag, input int stall, input bit gaps);
      logic [7:0]   xe, se;
      logic [255:0] xm, sm;
      logic         xo, xu;
      int           lat;
      bit           stable, rdy_low;
      for (int i = 0; i < gn; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge i_clk); #1;
         end
         if (i == 0) check({tag, "_ready"}, 256'(o_ready), 256'(1));
         i_valid    = 1'b1;
         i_mantissa = gm[i];
         i_exponent = 8'(ge[i]);
         i_last     = (i == gn - 1) ? (gn < 32 || glast) : 1'b0;
         @(posedge i_clk); #1;
      end
      // Garbage offered while busy must be ignored.
      i_valid    = 1'b1;
      i_mantissa = $urandom;
      i_exponent = 8'($urandom);
      i_last     = 1'b1;
      lat = 0;
      while (lat < 10) begin
         @(posedge i_clk); #1;
         lat++;
         if (o_valid) break;
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      check({tag, "_latency"}, 256'(lat), 256'(4));
      model(xe, xm, xo, xu);
      check({tag, "_exp"},   256'(o_exp),   256'(xe));
      check({tag, "_man"},   o_man,         xm);
      check({tag, "_count"}, 256'(o_count), 256'(gn));
      check({tag, "_flags"}, 256'({o_ovf, o_unf}), 256'({xo, xu}));
      se = o_exp; sm = o_man;
      stable = 1; rdy_low = (o_ready == 1'b0);
      for (int k = 0; k < stall; k++) begin
         @(posedge i_clk); #1;
         if (!(o_valid === 1'b1 && o_exp === se && o_man === sm)) stable = 0;
         if (o_ready !== 1'b0) rdy_low = 0;
      end
      check({tag, "_stall_stable"}, 256'(stable), 256'(1));
      check({tag, "_busy_not_ready"}, 256'(rdy_low), 256'(1));
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_post_hs"}, 256'({o_valid, o_ready}), 256'(2'b01));
   endtask

   initial begin
      i_reset_n = 1'b0; i_valid = 1'b0; i_mantissa = '0; i_exponent = '0;
      i_last = 1'b0; i_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_handshake", 256'({o_ready, o_valid}), 256'(0));
      check("rst_data", 256'({o_exp, o_count, o_ovf, o_unf}), 256'(0));
      check("rst_man", o_man, 256'(0));
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      check("rst_release_ready", 256'(o_ready), 256'(1));

      // T1: uniform ones
      fill(1, 0, 32, 1'b0);
      run_group("t1", 0, 1'b0);
      // T2: mixed signs/exponents
      fill(0, 0, 32, 1'b0);
      gm[0] = 127; ge[0] = 0; gm[1] = -8; ge[1] = -2;
      run_group("t2", 1, 1'b0);
      // T3: single element, overflow clamp
      fill(1, 30, 1, 1'b1);
      run_group("t3", 0, 1'b0);
      // T4: single element, underflow clamp
      fill(100, -40, 1, 1'b1);
      run_group("t4", 0, 1'b0);
      // T5: most negative mantissa, long stall
      fill(0, 0, 32, 1'b0);
      gm[0] = int'(32'h8000_0000);
      run_group("t5", 10, 1'b0);
      // i_last on the 32nd element behaves like the index wrap
      fill(-3, 5, 32, 1'b1);
      run_group("last32", 2, 1'b1);
      // All-zero group
      fill(0, 7, 12, 1'b1);
      run_group("zeros", 0, 1'b0);

      // T6: reset in the middle of a group at idx 17
      fill(77, 3, 32, 1'b0);
      for (int i = 0; i < 17; i++) begin
         i_valid = 1'b1; i_mantissa = 32'h7FFF_FFFF; i_exponent = 8'd90; i_last = 1'b0;
         @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      #2 i_reset_n = 1'b0;
      #1;
      check("t6_rst_outputs", 256'({o_ready, o_valid, o_exp, o_count, o_ovf, o_unf}), 256'(0));
      check("t6_rst_man", o_man, 256'(0));
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      run_group("t6_fresh", 0, 1'b0);

      // Randomized groups
      for (int g = 0; g < 25; g++) begin
         logic [31:0] v;
         gn = $urandom_range(1, 32);
         glast = 1'($urandom_range(0, 1));
         for (int i = 0; i < 32; i++) begin gm[i] = 0; ge[i] = 0; end
         for (int i = 0; i < gn; i++) begin
            case ($urandom_range(0, 7))
               0: v = 32'd0;
               1: v = 32'h8000_0000;
               default: begin
                  v = $urandom >> $urandom_range(0, 31);
                  if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
               end
            endcase
            gm[i] = int'(v);
            if ($urandom_range(0, 4) == 0) ge[i] = int'($signed(8'($urandom)));
            else                           ge[i] = int'($urandom_range(0, 40)) - 20;
         end
         run_group($sformatf("rnd%0d", g), int'($urandom_range(0, 3)), 1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
